output_port_arbiter: RTL and testbench

- Shares one router output port between NumReq input modules.
- Uses a round-robin pick per packet and holds a wormhole lock from head flit to last flit, counted via the head's pkt_size field.
- Sits between the input modules (flit + route request) and the output port's downstream flit interface.
- Provides the sequencing that keeps packets from interleaving on a link.

---
 rtl/ravenoc_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/output_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_output_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared flit/packet types for the router output arbitration path.
// The arbiter state enum lives here so the bench can name states directly.
package ravenoc_pkg;
    localparam int FlitWidth    = 34;
    localparam int FlitTpWidth  = 2;
    localparam int PktWidth     = 8;
    localparam int FlitPayloadW = FlitWidth - FlitTpWidth - PktWidth;

    typedef enum logic [FlitTpWidth-1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } flit_type_t;

    // Head flit layout: type in the top bits, flit count of the rest of the packet in the low bits.
    typedef struct packed {
        flit_type_t                type_f;
        logic [FlitPayloadW-1:0]   payload;
        logic [PktWidth-1:0]       pkt_size;
    } s_flit_head_data_t;

    typedef struct packed {
        logic [FlitWidth-1:0] fdata;
        logic                 valid;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        LOCKED
    } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NumReq = 4,
    parameter int PtrW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [PtrW-1:0]   i_rr_ptr,
    output logic [NumReq-1:0] o_grant,
    output logic [PtrW-1:0]   o_idx,
    output logic              o_vld
);
    logic [PtrW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_vld   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NumReq; k++) begin
            w_cand = PtrW'((int'(i_rr_ptr) + k) % NumReq);
            if (!o_vld && i_req[w_cand]) begin
                o_vld           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end
endmodule

// File: rtl/output_port_arbiter.sv
// Output-port arbiter: round-robin pick per packet, wormhole lock held from head
// until pkt_size further flits have been handed off downstream.
import ravenoc_pkg::*;

module output_port_arbiter #(
    parameter int NumReq = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  s_flit_req_t [NumReq-1:0] fin_req_i,
    input  logic [NumReq-1:0]        route_i,
    output s_flit_resp_t [NumReq-1:0] fin_resp_o,
    output s_flit_req_t              fout_req_o,
    input  s_flit_resp_t             fout_resp_i,
    output logic [NumReq-1:0]        grant_o,
    output logic                     busy_o,
    output logic                     proto_err_o
);
    localparam int PtrW = $clog2(NumReq);

    arb_state_t          r_state, w_next;
    logic [PktWidth-1:0] r_cnt, w_cnt_nxt;
    logic [PtrW-1:0]     r_lock_idx, w_lock_nxt;
    logic [PtrW-1:0]     r_rr_ptr, w_rr_nxt;
    logic                r_proto_err;

    logic [NumReq-1:0]   w_head_ok, w_bad;
    logic [NumReq-1:0]   w_arb_grant, w_grant;
    logic [PtrW-1:0]     w_arb_idx, w_gidx, w_wrap;
    logic                w_arb_vld, w_fire;
    logic [PktWidth-1:0] w_size;

    always_comb begin
        w_head_ok = '0;
        w_bad     = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_head_ok[i] = fin_req_i[i].valid && route_i[i] &&
                           (flit_type_t'(fin_req_i[i].fdata[FlitWidth-1 -: FlitTpWidth]) == HEAD_FLIT);
            w_bad[i]     = fin_req_i[i].valid && route_i[i] &&
                           (flit_type_t'(fin_req_i[i].fdata[FlitWidth-1 -: FlitTpWidth]) != HEAD_FLIT);
        end
    end

    rr_arbiter #(.NumReq(NumReq), .PtrW(PtrW)) u_rr (
        .i_req    (w_head_ok),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_arb_grant),
        .o_idx    (w_arb_idx),
        .o_vld    (w_arb_vld)
    );

    // Grant is forced off while reset is held so nothing leaks downstream during reset.
    always_comb begin
        w_grant = '0;
        w_gidx  = r_lock_idx;
        if (!arst) begin
            if (r_state == IDLE) begin
                w_grant = w_arb_grant;
                w_gidx  = w_arb_idx;
            end else begin
                w_grant[r_lock_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        fout_req_o = '0;
        if ((|w_grant) && route_i[w_gidx])
            fout_req_o = fin_req_i[w_gidx];
        for (int i = 0; i < NumReq; i++)
            fin_resp_o[i].ready = w_grant[i] && fout_resp_i.ready;
    end

    assign w_fire  = fout_req_o.valid && fout_resp_i.ready;
    assign w_size  = fin_req_i[w_gidx].fdata[PktWidth-1:0];
    assign w_wrap  = (w_gidx == PtrW'(NumReq-1)) ? '0 : w_gidx + 1'b1;
    assign grant_o = w_grant;
    assign busy_o  = (r_state != IDLE);
    assign proto_err_o = r_proto_err;

    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_lock_nxt = r_lock_idx;
        w_rr_nxt   = r_rr_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_arb_vld) begin
                    w_lock_nxt = w_arb_idx;
                    if (!w_fire) begin
                        w_next = HOLD;
                    end else if (w_size == '0) begin
                        w_rr_nxt = w_wrap;
                    end else begin
                        w_next    = LOCKED;
                        w_cnt_nxt = w_size;
                    end
                end
            end
            HOLD: begin
                if (w_fire) begin
                    if (w_size == '0) begin
                        w_next   = IDLE;
                        w_rr_nxt = w_wrap;
                    end else begin
                        w_next    = LOCKED;
                        w_cnt_nxt = w_size;
                    end
                end
            end
            LOCKED: begin
                // Count alone ends the packet; flit types are not inspected here.
                if (w_fire) begin
                    w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
                    if (r_cnt <= PktWidth'(1)) begin
                        w_next   = IDLE;
                        w_rr_nxt = w_wrap;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_lock_idx  <= '0;
            r_rr_ptr    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_nxt;
            r_lock_idx  <= w_lock_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_proto_err <= r_proto_err | ((r_state == IDLE) && (|w_bad));
        end
    end
endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed cycle table plus randomized traffic vs. a packet-level model.
import ravenoc_pkg::*;

module tb_output_port_arbiter;
    logic clk;
    logic arst;
    s_flit_req_t  [3:0] fin_req;
    logic         [3:0] route;
    s_flit_resp_t [3:0] fin_resp;
    s_flit_req_t        fout_req;
    s_flit_resp_t       fout_resp;
    logic         [3:0] grant;
    logic               busy;
    logic               perr;

    int n_chk  = 0;
    int n_fail = 0;

    output_port_arbiter #(.NumReq(4)) dut (
        .clk         (clk),
        .arst        (arst),
        .fin_req_i   (fin_req),
        .route_i     (route),
        .fin_resp_o  (fin_resp),
        .fout_req_o  (fout_req),
        .fout_resp_i (fout_resp),
        .grant_o     (grant),
        .busy_o      (busy),
        .proto_err_o (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] rte;
        logic [7:0] tp;
        logic [7:0] sz;
        logic       rdy;
        logic [3:0] eg;
        logic       ev;
        logic       eb;
        logic       ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] vld, logic [3:0] rte, logic [7:0] tp,
                                logic [7:0] sz, logic rdy, logic [3:0] eg, logic ev,
                                logic eb, logic ee);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rte = rte; v.tp = tp; v.sz = sz; v.rdy = rdy;
        v.eg = eg; v.ev = ev; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        s_flit_head_data_t h;
        arst = v.rst;
        route = v.rte;
        fout_resp.ready = v.rdy;
        for (int i = 0; i < 4; i++) begin
            h.type_f   = flit_type_t'(v.tp[2*i +: 2]);
            h.payload  = FlitPayloadW'(i * 16 + 5);
            h.pkt_size = v.sz;
            fin_req[i].fdata = h;
            fin_req[i].valid = v.vld[i];
        end
    endtask

    // Packet-level model state: owner<0 means no packet in flight; rem<0 means head not yet taken.
    int m_owner, m_rem, m_ptr;
    bit m_err;

    logic [3:0]          r_vld, r_rte;
    flit_type_t          r_tp [4];
    int                  r_sz [4];
    logic [FlitWidth-1:0] r_dat [4];

    initial begin
        vec_t v;
        s_flit_head_data_t h;
        logic [3:0] rv;
        logic rrst, rrdy, fire, fwd, ev;
        int g;
        logic [3:0] eg;
        logic [FlitWidth-1:0] ed;

        drive(mk(1, 4'b0000, 4'b0000, 8'h00, 8'd0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        // reset, then single-flit packet and rr pointer advance
        tbl.push_back(mk(1, 4'b0001, 4'b0001, 8'h00, 8'd0, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 8'h00, 8'd0, 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0011, 8'h00, 8'd0, 1, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 8'h00, 8'd0, 0, 4'b0000, 0, 0, 0));
        // two 4-flit packets back to back, no interleave
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 8'h00, 8'd3, 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 8'h01, 8'd3, 1, 4'b0001, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 8'h01, 8'd3, 1, 4'b0001, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 8'h02, 8'd3, 1, 4'b0001, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 8'h00, 8'd3, 1, 4'b0100, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 8'h10, 8'd3, 1, 4'b0100, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 8'h10, 8'd3, 1, 4'b0100, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 8'h20, 8'd3, 1, 4'b0100, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 8'd3, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 8'h00, 8'd0, 0, 4'b0000, 0, 0, 0));
        // HOLD: presented grant does not move while downstream stalls
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 8'h00, 8'd2, 0, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0011, 8'h00, 8'd2, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0011, 8'h00, 8'd2, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0011, 8'h00, 8'd2, 1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0011, 8'h04, 8'd2, 1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0011, 8'h08, 8'd2, 1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 8'h00, 8'd0, 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 8'h00, 8'd0, 0, 4'b0000, 0, 0, 0));
        // LOCKED bubbles on route low / valid low, then release and next head one cycle later
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 8'h00, 8'd2, 1, 4'b1000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 8'h40, 8'd2, 1, 4'b1000, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b1000, 8'h40, 8'd2, 1, 4'b1000, 0, 1, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 8'h40, 8'd2, 1, 4'b1000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1001, 4'b1001, 8'h80, 8'd0, 1, 4'b1000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 8'h00, 8'd0, 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 8'h00, 8'd0, 0, 4'b0000, 0, 0, 0));
        // protocol error: body flit seen in IDLE, sticky until reset
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 8'h04, 8'd0, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 8'h04, 8'd0, 1, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0110, 4'b0110, 8'h04, 8'd0, 1, 4'b0100, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 8'd0, 1, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 8'h00, 8'd0, 0, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 8'd0, 0, 4'b0000, 0, 0, 0));

        foreach (tbl[k]) begin
            v = tbl[k];
            @(negedge clk);
            drive(v);
            #1;
            rv = fin_resp;
            chk($sformatf("tbl%0d_grant", k), 64'(grant), 64'(v.eg));
            chk($sformatf("tbl%0d_fvalid", k), 64'(fout_req.valid), 64'(v.ev));
            chk($sformatf("tbl%0d_busy", k), 64'(busy), 64'(v.eb));
            chk($sformatf("tbl%0d_perr", k), 64'(perr), 64'(v.ee));
            chk($sformatf("tbl%0d_ready", k), 64'(rv), 64'(v.eg & {4{v.rdy}}));
        end

        // reset pulsed while a 6-flit packet is in flight (cnt=5)
        @(negedge clk);
        drive(mk(0, 4'b0001, 4'b0001, 8'h00, 8'd5, 1, 0, 0, 0, 0));
        #1 chk("mid_head_grant", 64'(grant), 64'h1);
        @(negedge clk);
        drive(mk(1, 4'b0001, 4'b0001, 8'h01, 8'd5, 1, 0, 0, 0, 0));
        #1 chk("mid_rst_grant", 64'(grant), 64'h0);
        chk("mid_rst_fvalid", 64'(fout_req.valid), 64'h0);
        @(negedge clk);
        drive(mk(0, 4'b0001, 4'b0001, 8'h01, 8'd5, 1, 0, 0, 0, 0));
        #1;
        chk("post_rst_state", 64'(dut.r_state), 64'(IDLE));
        chk("post_rst_rrptr", 64'(dut.r_rr_ptr), 64'h0);
        chk("post_rst_grant", 64'(grant), 64'h0);
        chk("post_rst_busy", 64'(busy), 64'h0);
        chk("post_rst_fvalid", 64'(fout_req.valid), 64'h0);

        // randomized traffic against the packet-level model
        m_owner = -1; m_rem = 0; m_ptr = 0; m_err = 0;
        @(negedge clk);
        drive(mk(1, 4'b0000, 4'b0000, 8'h00, 8'd0, 0, 0, 0, 0, 0));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rrst = ($urandom_range(0, 49) == 0);
            rrdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                int t;
                r_vld[i] = $urandom_range(0, 1);
                r_rte[i] = ($urandom_range(0, 3) != 0);
                t = $urandom_range(0, 9);
                r_tp[i]  = (t < 7) ? HEAD_FLIT : (t < 9) ? BODY_FLIT : TAIL_FLIT;
                r_sz[i]  = $urandom_range(0, 3);
                h.type_f   = r_tp[i];
                h.payload  = FlitPayloadW'($urandom);
                h.pkt_size = PktWidth'(r_sz[i]);
                r_dat[i]   = h;
                fin_req[i].fdata = r_dat[i];
                fin_req[i].valid = r_vld[i];
            end
            arst = rrst; route = r_rte; fout_resp.ready = rrdy;
            #1;
            g = -1;
            if (!rrst) begin
                if (m_owner < 0) begin
                    for (int k = 0; k < 4; k++) begin
                        int c;
                        c = (m_ptr + k) % 4;
                        if (g < 0 && r_vld[c] && r_rte[c] && r_tp[c] == HEAD_FLIT) g = c;
                    end
                end else begin
                    g = m_owner;
                end
            end
            eg  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            fwd = (g >= 0) && r_rte[g];
            ev  = fwd && r_vld[g];
            ed  = fwd ? r_dat[g] : '0;
            rv  = fin_resp;
            chk("rnd_grant", 64'(grant), 64'(eg));
            chk("rnd_fvalid", 64'(fout_req.valid), 64'(ev));
            chk("rnd_fdata", 64'(fout_req.fdata), 64'(ed));
            chk("rnd_ready", 64'(rv), 64'(eg & {4{rrdy}}));
            chk("rnd_busy", 64'(busy), 64'(m_owner >= 0));
            chk("rnd_perr", 64'(perr), 64'(m_err));
            if (rrst) begin
                m_owner = -1; m_rem = 0; m_ptr = 0; m_err = 0;
            end else begin
                fire = ev && rrdy;
                if (m_owner < 0)
                    for (int i = 0; i < 4; i++)
                        if (r_vld[i] && r_rte[i] && r_tp[i] != HEAD_FLIT) m_err = 1;
                if (g >= 0 && m_owner < 0) begin
                    m_owner = g; m_rem = -1;
                end
                if (m_owner >= 0 && fire) begin
                    if (m_rem < 0) begin
                        if (r_sz[g] == 0) begin
                            m_owner = -1; m_ptr = (g + 1) % 4;
                        end else begin
                            m_rem = r_sz[g];
                        end
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_owner = -1; m_ptr = (g + 1) % 4;
                        end
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
